// File: rtl/bpsk_modulator.sv
// BPSK transmitter: a byte FIFO feeds a frame sequencer (preamble, sync, 10-bit words, tail)
// whose current bit sets the sign of a 16-sample sine carrier sent to the DAC.
module bpsk_modulator #(
  parameter int         CYCLES_PER_BIT = 4,
  parameter int         PREAMBLE_BITS  = 32,
  parameter logic [7:0] SYNC_WORD      = 8'hA5,
  parameter int         TAIL_BITS      = 16,
  parameter int         AMPLITUDE      = 511,
  parameter int         FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sampleEn,
  input  logic              pushByte,
  input  logic [7:0]        Byte,
  input  logic              lastByte,
  output logic              stopOut,
  output logic signed [9:0] DAC,
  output logic              PushDAC,
  output logic              busy,
  output logic              overflow
);

  localparam int SAMPLES_PER_BIT = 16 * CYCLES_PER_BIT;
  localparam int SW    = $clog2(SAMPLES_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MAXB0 = (PREAMBLE_BITS > TAIL_BITS) ? PREAMBLE_BITS : TAIL_BITS;
  localparam int MAXB  = (MAXB0 > 10) ? MAXB0 : 10;
  localparam int BCW   = $clog2(MAXB);

  // First-quarter sine magnitudes, rounded from sin(2*pi*k/16) scaled by 2^15.
  localparam logic [9:0] MAG1 = 10'((AMPLITUDE * 12540 + 16384) / 32768);
  localparam logic [9:0] MAG2 = 10'((AMPLITUDE * 23170 + 16384) / 32768);
  localparam logic [9:0] MAG3 = 10'((AMPLITUDE * 30274 + 16384) / 32768);
  localparam logic [9:0] MAG4 = 10'(AMPLITUDE);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, FILL, TAIL} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sIdx_q, sIdx_d;
  logic [BCW-1:0]    bitCnt_q, bitCnt_d;
  logic [9:0]        word_q, word_d;
  logic              last_q, last_d;
  logic [8:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              stop_q, overflow_q, pushDac_q;
  logic signed [9:0] dac_q;

  logic              pop, pushOk, fifoNotEmpty, lastSample, boundary, loadWord, txBit;
  logic [8:0]        headEntry;
  logic [7:0]        syncShift;
  logic [2:0]        lutPos;
  logic [9:0]        lutMag;
  logic signed [9:0] lutVal, sample;

  assign stopOut  = stop_q;
  assign overflow = overflow_q;
  assign PushDAC  = pushDac_q;
  assign DAC      = dac_q;
  assign busy     = (state_q != IDLE);

  assign fifoNotEmpty = (count_q != '0);
  assign headEntry    = mem_q[rdPtr_q];
  // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
  assign pushOk       = pushByte && (!stop_q || pop);

  always_comb begin
    count_d = count_q;
    if (pushOk && !pop)      count_d = count_q + 1'b1;
    else if (!pushOk && pop) count_d = count_q - 1'b1;
  end

  assign lastSample = (sIdx_q == SW'(SAMPLES_PER_BIT - 1));
  // IDLE holds the sample index at zero so a frame may start on any strobe.
  assign boundary   = sampleEn && (state_q == IDLE || lastSample);

  always_comb begin
    state_d  = state_q;
    sIdx_d   = sIdx_q;
    bitCnt_d = bitCnt_q;
    word_d   = word_q;
    last_d   = last_q;
    pop      = 1'b0;
    loadWord = 1'b0;
    if (sampleEn) sIdx_d = (state_q == IDLE || lastSample) ? '0 : sIdx_q + 1'b1;
    if (boundary) begin
      bitCnt_d = bitCnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          bitCnt_d = '0;
          if (fifoNotEmpty) state_d = PREAMBLE;
        end
        PREAMBLE: if (bitCnt_q == BCW'(PREAMBLE_BITS - 1)) begin
          state_d  = SYNC;
          bitCnt_d = '0;
        end
        SYNC: if (bitCnt_q == BCW'(7)) loadWord = 1'b1;
        DATA: if (bitCnt_q == BCW'(9)) begin
          if (last_q) begin
            state_d  = TAIL;
            bitCnt_d = '0;
          end else begin
            loadWord = 1'b1;
          end
        end
        FILL: loadWord = 1'b1;
        TAIL: if (bitCnt_q == BCW'(TAIL_BITS - 1)) begin
          state_d  = IDLE;
          bitCnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
      if (loadWord) begin
        bitCnt_d = '0;
        if (fifoNotEmpty) begin
          pop     = 1'b1;
          state_d = DATA;
          word_d  = {1'b1, headEntry[7:0], 1'b0};
          last_d  = headEntry[8];
        end else begin
          state_d = FILL;
        end
      end
    end
  end

  assign syncShift = SYNC_WORD << bitCnt_q[2:0];

  always_comb begin
    txBit = 1'b1;
    unique case (state_q)
      PREAMBLE: txBit = ~bitCnt_q[0];
      SYNC:     txBit = syncShift[7];
      DATA:     txBit = word_q[bitCnt_q[3:0]];
      default:  txBit = 1'b1;
    endcase
  end

  // Fold the 16-entry sine onto its first quarter; the second half is the negated first.
  assign lutPos = (sIdx_q[2:0] > 3'd4) ? 3'd0 - sIdx_q[2:0] : sIdx_q[2:0];

  always_comb begin
    lutMag = '0;
    unique case (lutPos)
      3'd1:    lutMag = MAG1;
      3'd2:    lutMag = MAG2;
      3'd3:    lutMag = MAG3;
      3'd4:    lutMag = MAG4;
      default: lutMag = '0;
    endcase
  end

  assign lutVal = sIdx_q[3] ? -$signed(lutMag) : $signed(lutMag);
  assign sample = (state_q == IDLE) ? '0 : (txBit ? lutVal : -lutVal);

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= {lastByte, Byte};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sIdx_q     <= '0;
      bitCnt_q   <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
      pushDac_q  <= 1'b0;
      dac_q      <= '0;
    end else begin
      state_q    <= state_d;
      sIdx_q     <= sIdx_d;
      bitCnt_q   <= bitCnt_d;
      word_q     <= word_d;
      last_q     <= last_d;
      count_q    <= count_d;
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
      stop_q     <= (count_d == CNT_W'(FIFO_DEPTH));
      overflow_q <= pushByte && stop_q && !pop;
      pushDac_q  <= sampleEn;
      if (sampleEn) dac_q <= sample;
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Bench for bpsk_modulator: a vector table, hand-built frame sequences decoded from the
// DAC stream, and randomized traffic checked cycle by cycle against a frame-level model.
module tb_bpsk_modulator;

  localparam int AMP = 511;

  logic              clk = 1'b0;
  logic              reset, sampleEn, pushByte, lastByte;
  logic [7:0]        byteIn;
  logic              stopOut, PushDAC, busy, overflow;
  logic signed [9:0] DAC;

  bpsk_modulator dut (
    .clk(clk), .reset(reset), .sampleEn(sampleEn), .pushByte(pushByte), .Byte(byteIn),
    .lastByte(lastByte), .stopOut(stopOut), .DAC(DAC), .PushDAC(PushDAC), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Model state: the FIFO as a queue, the frame as a queue of bits still to send.
  int                lut [16];
  logic [8:0]        mFifo [$];
  bit                mBits [$];
  bit                mInFrame, mEnding, mLastSent;
  int                mS;
  logic signed [9:0] mDac;
  bit                mPush, mStop, mOvf;

  bit                expQ [$];
  int                rec [$];
  bit                sawOvf;
  logic [7:0]        syncWord = 8'hA5;

  typedef struct {
    logic rst, push; logic [7:0] b; logic last, en;
    logic stop, ovf, busy, pdac; int dac;
  } vec_t;
  vec_t vecs [12];

  function automatic void check(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void modelStep(input logic r, p, input logic [7:0] b, input logic l, e);
    bit popNow = 0;
    logic [8:0] ent;
    logic [9:0] w;
    if (!r) begin
      mFifo.delete(); mBits.delete();
      mInFrame = 0; mS = 0; mDac = 0; mPush = 0; mStop = 0; mOvf = 0;
      return;
    end
    mPush = e;
    mOvf  = 0;
    if (e) begin
      if (!mInFrame) begin
        mDac = 0;
        if (mFifo.size() > 0) begin
          mInFrame = 1; mEnding = 0; mLastSent = 0; mS = 0;
          for (int i = 0; i < 32; i++) mBits.push_back(i % 2 == 0);
          for (int i = 0; i < 8; i++) mBits.push_back(syncWord[7-i]);
        end
      end else begin
        mDac = 10'(mBits[0] ? lut[mS % 16] : -lut[mS % 16]);
        mS++;
        if (mS == 64) begin
          mS = 0;
          void'(mBits.pop_front());
          if (mBits.size() == 0) begin
            if (mEnding) mInFrame = 0;
            else if (mLastSent) begin
              for (int i = 0; i < 16; i++) mBits.push_back(1'b1);
              mEnding = 1;
            end else if (mFifo.size() > 0) begin
              ent = mFifo.pop_front();
              popNow = 1;
              w = {1'b1, ent[7:0], 1'b0};
              for (int i = 0; i < 10; i++) mBits.push_back(w[i]);
              mLastSent = ent[8];
            end else mBits.push_back(1'b1);
          end
        end
      end
    end
    if (p) begin
      if (!mStop || popNow) mFifo.push_back({l, b});
      else mOvf = 1;
    end
    mStop = (mFifo.size() == 4);
  endfunction

  task automatic checkOutput();
    int act, exp;
    act = int'({DAC, PushDAC, busy, stopOut, overflow});
    exp = int'({mDac, mPush, mInFrame, mStop, mOvf});
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL model t=%0t: got DAC=%0d push=%0b busy=%0b stop=%0b ovf=%0b, expected DAC=%0d push=%0b busy=%0b stop=%0b ovf=%0b",
               $time, DAC, PushDAC, busy, stopOut, overflow, mDac, mPush, mInFrame, mStop, mOvf);
    end
  endtask

  task automatic applyStimulus(input logic r, p, input logic [7:0] b, input logic l, e);
    reset = r; pushByte = p; byteIn = b; lastByte = l; sampleEn = e;
    @(posedge clk);
    modelStep(r, p, b, l, e);
    #1;
    checkOutput();
  endtask

  task automatic runStrobes(input int n, input int gap, input int pushAt,
                            input logic [7:0] pb, input logic pl);
    int strobes = 0;
    int cyc = 0;
    logic en;
    rec.delete();
    sawOvf = 0;
    while (strobes < n) begin
      en = (cyc % gap == 0);
      applyStimulus(1'b1, en && (strobes == pushAt), pb, pl, en);
      if (PushDAC) rec.push_back(int'(DAC));
      if (overflow) sawOvf = 1;
      if (en) strobes++;
      cyc++;
    end
  endtask

  function automatic void expStart();
    expQ.delete();
    for (int i = 0; i < 32; i++) expQ.push_back(i % 2 == 0);
    for (int i = 0; i < 8; i++) expQ.push_back(syncWord[7-i]);
  endfunction

  function automatic void expWord(input logic [7:0] b);
    logic [9:0] w;
    w = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) expQ.push_back(w[i]);
  endfunction

  function automatic void expOnes(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(1'b1);
  endfunction

  // Each bit is read from its k=4 sample, where the carrier peaks at +/-AMP.
  task automatic checkFrame(input string name, input int base);
    int idx, got;
    for (int b = 0; b < expQ.size(); b++) begin
      idx = base + 64 * b + 4;
      got = 2;
      if (idx >= 0 && idx < rec.size()) begin
        if (rec[idx] == AMP) got = 1;
        else if (rec[idx] == -AMP) got = 0;
      end
      check($sformatf("%s bit %0d", name, b), got, int'(expQ[b]));
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++)
      lut[k] = int'($floor(AMP * $sin(2.0 * 3.14159265358979 * k / 16.0) + 0.5));

    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 196};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 196};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 361};

    // Reset, fill the FIFO past full, then start the frame and watch its first samples.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].push, vecs[i].b, vecs[i].last, vecs[i].en);
      check($sformatf("vec%0d stopOut", i), int'(stopOut), int'(vecs[i].stop));
      check($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("vec%0d PushDAC", i), int'(PushDAC), int'(vecs[i].pdac));
      check($sformatf("vec%0d DAC", i), int'(DAC), vecs[i].dac);
    end
    runStrobes(96 * 64 + 3, 1, -1, 8'h00, 1'b0);
    expStart(); expWord(8'h11); expWord(8'h22); expWord(8'h33); expWord(8'h44); expOnes(16);
    checkFrame("fifo4", -3);
    check("fifo4 busy end", int'(busy), 0);
    check("fifo4 stop end", int'(stopOut), 0);

    // Single byte 3C: full frame bit stream.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
    runStrobes(66 * 64 + 8, 1, -1, 8'h00, 1'b0);
    expStart(); expWord(8'h3C); expOnes(16);
    checkFrame("byte3C", 1);
    check("byte3C idle sample", rec[66 * 64 + 3], 0);
    check("byte3C busy end", int'(busy), 0);

    // Reset in the middle of a data word.
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
    runStrobes(45 * 64 + 20, 1, -1, 8'h00, 1'b0);
    check("midreset busy before", int'(busy), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("midreset PushDAC", int'(PushDAC), 1);
    check("midreset DAC", int'(DAC), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset stopOut", int'(stopOut), 0);

    // Underrun: second byte arrives during the third fill bit.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    runStrobes(79 * 64 + 5, 1, 1 + 64 * 52 + 10, 8'h5A, 1'b1);
    expStart(); expWord(8'h00); expOnes(3); expWord(8'h5A); expOnes(16);
    checkFrame("underrun", 1);

    // Push lands exactly on the pop that ends the sync word while the FIFO is full.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    check("pushpop full", int'(stopOut), 1);
    runStrobes(106 * 64 + 5, 1, 1 + 64 * 39 + 63, 8'h05, 1'b1);
    check("pushpop no overflow", int'(sawOvf), 0);
    expStart();
    for (int i = 1; i <= 5; i++) expWord(8'(i));
    expOnes(16);
    checkFrame("pushpop", 1);

    // Sparse strobes: one every third cycle.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h96, 1'b1, 1'b0);
    runStrobes(66 * 64 + 5, 3, -1, 8'h00, 1'b0);
    check("sparse sample count", rec.size(), 66 * 64 + 5);
    expStart(); expWord(8'h96); expOnes(16);
    checkFrame("sparse", 1);

    // Random traffic against the model.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 15000; i++)
      applyStimulus(($urandom % 5000) != 0, ($urandom % 8) == 0, 8'($urandom),
                    ($urandom % 4) == 0, ($urandom % 3) != 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
